gate_model_bist: RTL
====================

// Module: gate_model_bist
// PURPOSE
//  Parametrised built-in self-test wrapper for the generated combinational gate models of the
//  simulator gate library. An LFSR drives N_IN pseudo-random patterns into the model under
//  test, a MISR compacts its N_OUT responses into a signature, and the result is compared with
//  a golden value. Sits between the lab control logic and one gate model instance.
// PARAMETERS
//  N_IN       23           pattern width = model input count (>=2)
//  N_OUT      10           response width = model output count (1..MISR_W)
//  MISR_W     16           signature width
//  LFSR_POLY  23'h420000   LFSR feedback tap mask, N_IN bits
//  MISR_POLY  16'hB400     MISR feedback tap mask, MISR_W bits
//  CNT_W      16           pattern counter width
//  RESP_LAT   0            model response latency in clocks (0..3)
// PORTS
//  clk          in   1        clock
//  rst_n        in   1        synchronous reset, active low
//  start_i      in   1        start run (sampled in IDLE only)
//  abort_i      in   1        abandon run, return to IDLE
//  num_pat_i    in   CNT_W    pattern count, latched on start
//  seed_i       in   N_IN     LFSR seed, latched on start
//  golden_i     in   MISR_W   expected signature, sampled in DONE
//  pat_o        out  N_IN     pattern to model inputs
//  resp_i       in   N_OUT    model outputs
//  busy_o       out  1        high in RUN/FLUSH/DONE
//  done_o       out  1        one-cycle pulse, run complete
//  sig_o        out  MISR_W   final signature
//  sig_valid_o  out  1        sig_o/pass_o valid
//  pass_o       out  1        sig_o == golden_i
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state IDLE; pat_o, sig_o, counters, MISR = 0; busy_o, done_o,
//    sig_valid_o, pass_o = 0. Reset mid-run discards the run; no done_o.
//  - States IDLE -> RUN -> FLUSH -> DONE -> IDLE.
//  - IDLE: start_i=1 at edge: lfsr <= seed_i (seed_i==0 replaced by 1, lock-up guard),
//    MISR <= 0, cnt <= num_pat_i, sig_valid_o <= 0; go RUN. num_pat_i==0: go FLUSH directly.
//  - RUN: pat_o = lfsr (registered). Each edge: lfsr <= {lfsr[N_IN-2:0], ^(lfsr & LFSR_POLY)},
//    cnt--, a valid token enters a RESP_LAT-deep delay line; cnt reaching 0 -> FLUSH.
//  - Capture: a token leaving the delay line (same edge for RESP_LAT=0) updates
//    misr <= {misr[MISR_W-2:0], ^(misr & MISR_POLY)} ^ zero-extend(resp_i).
//  - FLUSH: hold pat_o; stay until delay line empty (0 cycles extra for RESP_LAT=0), then DONE.
//  - DONE (1 cycle): done_o=1; at edge sig_o <= misr, pass_o <= (misr==golden_i),
//    sig_valid_o <= 1; go IDLE. sig_o/pass_o/sig_valid_o hold until next start or abort.
//  - Timing: start edge k -> patterns at cycles k+1..k+N -> done_o high in cycle k+N+RESP_LAT+1.
//  - start_i ignored when not IDLE. abort_i has priority over start_i and all transitions:
//    next state IDLE, sig_valid_o <= 0, pass_o <= 0, no done_o; abort in IDLE clears valid only.
//  - Counter and LFSR wrap naturally; no overflow detection. Exactly num_pat_i captures per run.
// STRUCTURE
//  - Package gate_model_bist_pkg: state enum (IDLE,RUN,FLUSH,DONE), LFSR/MISR step functions.
//  - Sub-module gm_lfsr_core (width, poly, parallel input, enable), instantiated for LFSR
//    (input 0) and MISR (input resp_i). FSM, counter, delay line in top.
// TESTING (bench: N_IN=4, LFSR_POLY=4'b1001, N_OUT=4, MISR_W=4, MISR_POLY=4'b1001)
//  1 seed 1, N=4, RESP_LAT=0 -> pat_o 0001,0011,0111,1111; done_o 5 cycles after start edge.
//  2 seed 1, N=16 -> pattern 16 equals pattern 1 (period 15); seed 0 -> first pattern 0001.
//  3 resp_i tied 0, N=10, golden 0 -> sig_o=0, pass_o=1; golden 5 -> pass_o=0.
//  4 resp_i = pat_o, RESP_LAT=2 -> done_o at start+N+3; sig_o equals reference-model value.
//  5 abort_i in RUN cycle 2 -> IDLE next cycle, no done_o, sig_valid_o=0; restart completes.
//  6 start_i during RUN ignored; rst_n low mid-run -> all outputs 0, state IDLE.

Source files
------------

// File: rtl/gate_model_bist_pkg.sv
// Shared types and shift-register step functions for the gate-model BIST wrapper.
// Contents:
//   state_e     : run sequencer states (IDLE, RUN, FLUSH, DONE)
//   STEP_MAX_W  : widest shift register the step functions handle
//   lfsr_step   : one Fibonacci-style LFSR advance (shift left, parity of taps into bit 0)
//   misr_step   : one MISR advance (LFSR advance XOR parallel response word)
package gate_model_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned STEP_MAX_W = 64;

  // Operands are zero-extended to STEP_MAX_W; only the low w bits are meaningful
  // and bits at or above w in the result are forced to zero.
  function automatic logic [STEP_MAX_W-1:0] lfsr_step(
    input logic [STEP_MAX_W-1:0] s,
    input logic [STEP_MAX_W-1:0] poly,
    input int unsigned           w
  );
    logic [STEP_MAX_W-1:0] r;
    r    = '0;
    r[0] = ^(s & poly);
    for (int unsigned i = 1; i < STEP_MAX_W; i++) begin
      if (i < w) r[i] = s[i-1];
    end
    return r;
  endfunction

  function automatic logic [STEP_MAX_W-1:0] misr_step(
    input logic [STEP_MAX_W-1:0] s,
    input logic [STEP_MAX_W-1:0] poly,
    input logic [STEP_MAX_W-1:0] par,
    input int unsigned           w
  );
    return lfsr_step(s, poly, w) ^ par;
  endfunction

endpackage

// File: rtl/gm_lfsr_core.sv
// Loadable shift-register core used both as pattern LFSR and as response MISR.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset (state cleared to 0)
//   load_i       : load load_val_i (has priority over en_i)
//   load_val_i   : W-bit value to load
//   en_i         : advance one step, XORing par_i into the shifted word
//   par_i        : W-bit parallel input (tie to 0 for a plain LFSR)
//   state_o      : current register contents
// W must not exceed STEP_MAX_W.
module gm_lfsr_core
  import gate_model_bist_pkg::*;
#(
  parameter int unsigned W    = 16,
  parameter logic [W-1:0] POLY = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic [W-1:0] par_i,
  output logic [W-1:0] state_o
);

  logic [W-1:0]            state_q, state_d;
  logic [STEP_MAX_W-1:0]   state_ext, poly_ext, par_ext, step_ext;
  logic                    unused_step;

  always_comb begin
    state_ext        = '0;
    poly_ext         = '0;
    par_ext          = '0;
    state_ext[W-1:0] = state_q;
    poly_ext[W-1:0]  = POLY;
    par_ext[W-1:0]   = par_i;
    step_ext         = misr_step(state_ext, poly_ext, par_ext, W);
  end

  // Upper bits of the widened step result are always zero.
  assign unused_step = ^step_ext;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = load_val_i;
    end else if (en_i) begin
      state_d = step_ext[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/gate_model_bist.sv
// BIST wrapper for one combinational gate model: an LFSR drives pseudo-random
// patterns into the model, a MISR compacts its responses, and the final signature
// is compared against a golden value.
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   start_i       : start a run (only honoured in IDLE)
//   abort_i       : abandon any run and return to IDLE (highest priority)
//   num_pat_i     : number of patterns, latched on start
//   seed_i        : LFSR seed, latched on start (0 is replaced by 1)
//   golden_i      : expected signature, sampled in DONE
//   pat_o         : registered pattern to the model inputs
//   resp_i        : model outputs, RESP_LAT clocks behind pat_o
//   busy_o        : high in RUN/FLUSH/DONE
//   done_o        : one-cycle pulse when a run completes
//   sig_o         : final signature
//   sig_valid_o   : sig_o/pass_o valid
//   pass_o        : signature matched golden_i
module gate_model_bist
  import gate_model_bist_pkg::*;
#(
  parameter int unsigned       N_IN      = 23,
  parameter int unsigned       N_OUT     = 10,
  parameter int unsigned       MISR_W    = 16,
  parameter logic [N_IN-1:0]   LFSR_POLY = 23'h420000,
  parameter logic [MISR_W-1:0] MISR_POLY = 16'hB400,
  parameter int unsigned       CNT_W     = 16,
  parameter int unsigned       RESP_LAT  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [CNT_W-1:0]  num_pat_i,
  input  logic [N_IN-1:0]   seed_i,
  input  logic [MISR_W-1:0] golden_i,
  output logic [N_IN-1:0]   pat_o,
  input  logic [N_OUT-1:0]  resp_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [MISR_W-1:0] sig_o,
  output logic              sig_valid_o,
  output logic              pass_o
);

  // Delay line needs at least one bit to be declarable; unused when RESP_LAT == 0.
  localparam int unsigned DLW = (RESP_LAT == 0) ? 1 : RESP_LAT;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DLW-1:0]      dl_q, dl_d;
  logic [MISR_W-1:0]   sig_q, sig_d;
  logic                pass_q, pass_d;
  logic                valid_q, valid_d;

  logic                lfsr_load, lfsr_en;
  logic                misr_load, misr_en;
  logic                run_tok;
  logic                capture;
  logic                pending;
  logic [N_IN-1:0]     seed_fix;
  logic [N_IN-1:0]     lfsr_state;
  logic [MISR_W-1:0]   misr_state;
  logic [MISR_W-1:0]   resp_ext;

  assign seed_fix = (seed_i == '0) ? {{(N_IN-1){1'b0}}, 1'b1} : seed_i;

  always_comb begin
    resp_ext             = '0;
    resp_ext[N_OUT-1:0]  = resp_i;
  end

  // Tokens still in flight other than the one leaving the line this edge.
  always_comb begin
    pending = 1'b0;
    for (int unsigned i = 0; i + 1 < DLW; i++) begin
      pending = pending | dl_q[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sig_d     = sig_q;
    pass_d    = pass_q;
    valid_d   = valid_q;
    lfsr_load = 1'b0;
    lfsr_en   = 1'b0;
    misr_load = 1'b0;
    run_tok   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          lfsr_load = 1'b1;
          misr_load = 1'b1;
          cnt_d     = num_pat_i;
          valid_d   = 1'b0;
          state_d   = (num_pat_i == '0) ? ST_FLUSH : ST_RUN;
        end
      end
      ST_RUN: begin
        lfsr_en = 1'b1;
        run_tok = 1'b1;
        cnt_d   = cnt_q - CNT_W'(1);
        // With zero latency the last capture coincides with the last pattern,
        // so FLUSH would only add a dead cycle.
        if (cnt_q == CNT_W'(1)) begin
          state_d = (RESP_LAT == 0) ? ST_DONE : ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (!pending) state_d = ST_DONE;
      end
      ST_DONE: begin
        sig_d   = misr_state;
        pass_d  = (misr_state == golden_i);
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort_i) begin
      state_d   = ST_IDLE;
      cnt_d     = cnt_q;
      sig_d     = sig_q;
      valid_d   = 1'b0;
      pass_d    = (state_q == ST_IDLE) ? pass_q : 1'b0;
      lfsr_load = 1'b0;
      lfsr_en   = 1'b0;
      misr_load = 1'b0;
      run_tok   = 1'b0;
    end
  end

  always_comb begin
    dl_d    = dl_q;
    dl_d[0] = (RESP_LAT != 0) && run_tok;
    for (int unsigned i = 1; i < DLW; i++) begin
      dl_d[i] = dl_q[i-1];
    end
    if (abort_i) dl_d = '0;
  end

  assign capture = (RESP_LAT == 0) ? run_tok : dl_q[DLW-1];
  assign misr_en = capture && !abort_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dl_q    <= '0;
      sig_q   <= '0;
      pass_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dl_q    <= dl_d;
      sig_q   <= sig_d;
      pass_q  <= pass_d;
      valid_q <= valid_d;
    end
  end

  gm_lfsr_core #(
    .W    (N_IN),
    .POLY (LFSR_POLY)
  ) u_lfsr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (lfsr_load),
    .load_val_i (seed_fix),
    .en_i       (lfsr_en),
    .par_i      ('0),
    .state_o    (lfsr_state)
  );

  gm_lfsr_core #(
    .W    (MISR_W),
    .POLY (MISR_POLY)
  ) u_misr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (misr_load),
    .load_val_i ('0),
    .en_i       (misr_en),
    .par_i      (resp_ext),
    .state_o    (misr_state)
  );

  assign pat_o       = lfsr_state;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE) && !abort_i;
  assign sig_o       = sig_q;
  assign sig_valid_o = valid_q;
  assign pass_o      = pass_q;

endmodule
